// File: rtl/handshake_fifo_buffer_if.sv
// Valid/ready token channels around handshake_fifo_buffer: an input channel (ins*)
// and an output channel (outs*). master = producer/consumer side, slave = the buffer.
interface handshake_fifo_buffer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] ins;
  logic                  ins_valid;
  logic                  ins_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;

  modport master (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid
  );

  modport slave (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid
  );
endinterface

// File: rtl/handshake_fifo_buffer.sv
// Elastic DEPTH-slot FIFO between handshake units; ins_ready depends on registered
// occupancy only. Optional same-cycle pass-through when empty: HANDSHAKE_FIFO_BYPASS_EN.
module handshake_fifo_buffer #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  handshake_fifo_buffer_if.slave bus,
  output logic [CW-1:0]          count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] slot;
  logic [PW-1:0]                    wr_ptr, rd_ptr;
  logic                             push, pop, full, empty;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full          = (count == CW'(DEPTH));
  assign empty         = (count == '0);
  assign bus.ins_ready = !full;
  assign pop           = !empty & bus.outs_ready;

`ifdef HANDSHAKE_FIFO_BYPASS_EN
  logic bypass;
  // Gated by rst so outs stays 0 while reset is held even if ins is driven.
  assign bypass         = empty & bus.ins_valid & rst;
  assign bus.outs_valid = !empty | bypass;
  assign bus.outs       = bypass ? bus.ins : slot[rd_ptr];
  // A token consumed on the pass-through path never touches storage.
  assign push           = bus.ins_valid & !full & !(bypass & bus.outs_ready);
`else
  assign bus.outs_valid = !empty;
  assign bus.outs       = slot[rd_ptr];
  assign push           = bus.ins_valid & !full;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      slot <= '0;
    else if (push) slot[wr_ptr] <= bus.ins;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end
endmodule
